// File: rtl/float_adder_pipe.sv
// Three-stage pipelined IEEE-754 style adder/subtractor with flush-to-zero and a shared stall.
// Define FADD_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module float_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out,
    output logic                     NaN_flag,
    output logic                     overflow_flag
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SIG = MAN_W + 1;
    localparam int EXT = MAN_W + 4;
    localparam int XW  = EXP_W + 2;
    localparam int unsigned SHIFT_LIM = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, classify, compare, align ----------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_nan, b_nan, a_inf, b_inf, a_ge_b;
    logic             big_sign;
    logic [EXP_W-1:0] big_exp, small_exp, diff;
    logic [SIG-1:0]   big_sig, small_sig;
    logic [EXT-1:0]   small_ext, lost, aligned;

    always_comb begin
        a_sign = A[W-1];
        b_sign = B[W-1] ^ op;
        a_exp  = A[W-2:MAN_W];
        b_exp  = B[W-2:MAN_W];
        a_man  = (a_exp == '0) ? '0 : A[MAN_W-1:0];
        b_man  = (b_exp == '0) ? '0 : B[MAN_W-1:0];
        a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
        a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
        a_ge_b = {a_exp, a_man} >= {b_exp, b_man};

        big_sign  = a_ge_b ? a_sign : b_sign;
        big_exp   = a_ge_b ? a_exp : b_exp;
        small_exp = a_ge_b ? b_exp : a_exp;
        big_sig   = a_ge_b ? {a_exp != '0, a_man} : {b_exp != '0, b_man};
        small_sig = a_ge_b ? {b_exp != '0, b_man} : {a_exp != '0, a_man};

        diff      = big_exp - small_exp;
        small_ext = {small_sig, 3'b000};
        lost      = small_ext & ~({EXT{1'b1}} << diff);
        aligned   = (small_ext >> diff) | {{(EXT-1){1'b0}}, |lost};
        if (32'(diff) >= SHIFT_LIM)
            aligned = {{(EXT-1){1'b0}}, |small_sig};
    end

    logic             s1_valid_reg, s1_sign_reg, s1_sub_reg;
    logic             s1_nan_reg, s1_inf_reg, s1_inf_sign_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [SIG-1:0]   s1_big_reg;
    logic [EXT-1:0]   s1_small_reg;

    // ---------------- S2: significand add / subtract ----------------
    // The big operand has the larger magnitude, so subtraction never goes negative.
    logic [EXT:0] sum;
    assign sum = s1_sub_reg ? ({1'b0, s1_big_reg, 3'b000} - {1'b0, s1_small_reg})
                            : ({1'b0, s1_big_reg, 3'b000} + {1'b0, s1_small_reg});

    logic             s2_valid_reg, s2_sign_reg, s2_sub_reg;
    logic             s2_nan_reg, s2_inf_reg, s2_inf_sign_reg;
    logic [EXP_W-1:0] s2_exp_reg;
    logic [EXT:0]     s2_sum_reg;

    // ---------------- S3: normalise, round, pack, special select ----------------
    int                      lz;
    logic [EXT-1:0]          norm;
    logic signed [XW-1:0]    exp_base, exp_n, exp_f;
    logic                    round_up;
    logic [SIG:0]            rounded;
    logic [MAN_W-1:0]        man_f;
    logic [W-1:0]            res;
    logic                    res_nan, res_ovf;

`ifndef FADD_ROUND_NEAREST_EN
    logic grs_unused;
    assign grs_unused = ^norm[2:0];
`endif

    always_comb begin
        lz = EXT;
        for (int i = 0; i < EXT; i++)
            if (s2_sum_reg[i]) lz = EXT - 1 - i;

        exp_base = $signed({2'b00, s2_exp_reg});
        if (s2_sum_reg[EXT]) begin
            norm  = {s2_sum_reg[EXT:2], s2_sum_reg[1] | s2_sum_reg[0]};
            exp_n = exp_base + XW'(1);
        end else begin
            norm  = s2_sum_reg[EXT-1:0] << lz;
            exp_n = exp_base - XW'(lz);
        end

`ifdef FADD_ROUND_NEAREST_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
        round_up = 1'b0;
`endif
        rounded = {1'b0, norm[EXT-1:3]} + {{SIG{1'b0}}, round_up};
        if (rounded[SIG]) begin
            man_f = rounded[SIG-1:1];
            exp_f = exp_n + XW'(1);
        end else begin
            man_f = rounded[MAN_W-1:0];
            exp_f = exp_n;
        end

        res_nan = 1'b0;
        res_ovf = 1'b0;
        if (s2_nan_reg) begin
            res     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            res_nan = 1'b1;
        end else if (s2_inf_reg) begin
            res = {s2_inf_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_sum_reg == '0) begin
            // Exact cancellation is +0; same-sign zeros keep their sign.
            res = {s2_sign_reg & !s2_sub_reg, {(W-1){1'b0}}};
        end else if (exp_n <= 0) begin
            res = {s2_sign_reg, {(W-1){1'b0}}};
        end else if (exp_f >= $signed({2'b00, EXP_ONES})) begin
            res     = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            res_ovf = 1'b1;
        end else begin
            res = {s2_sign_reg, exp_f[EXP_W-1:0], man_f};
        end
    end

    logic [W-1:0] out_reg;
    logic         out_valid_reg, nan_reg, ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg    <= 1'b0;
            s1_sign_reg     <= 1'b0;
            s1_sub_reg      <= 1'b0;
            s1_nan_reg      <= 1'b0;
            s1_inf_reg      <= 1'b0;
            s1_inf_sign_reg <= 1'b0;
            s1_exp_reg      <= '0;
            s1_big_reg      <= '0;
            s1_small_reg    <= '0;
            s2_valid_reg    <= 1'b0;
            s2_sign_reg     <= 1'b0;
            s2_sub_reg      <= 1'b0;
            s2_nan_reg      <= 1'b0;
            s2_inf_reg      <= 1'b0;
            s2_inf_sign_reg <= 1'b0;
            s2_exp_reg      <= '0;
            s2_sum_reg      <= '0;
            out_valid_reg   <= 1'b0;
            out_reg         <= '0;
            nan_reg         <= 1'b0;
            ovf_reg         <= 1'b0;
        end else if (adv) begin
            s1_valid_reg    <= in_valid;
            s1_sign_reg     <= big_sign;
            s1_sub_reg      <= a_sign ^ b_sign;
            s1_nan_reg      <= a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
            s1_inf_reg      <= a_inf | b_inf;
            s1_inf_sign_reg <= a_inf ? a_sign : b_sign;
            s1_exp_reg      <= big_exp;
            s1_big_reg      <= big_sig;
            s1_small_reg    <= aligned;
            s2_valid_reg    <= s1_valid_reg;
            s2_sign_reg     <= s1_sign_reg;
            s2_sub_reg      <= s1_sub_reg;
            s2_nan_reg      <= s1_nan_reg;
            s2_inf_reg      <= s1_inf_reg;
            s2_inf_sign_reg <= s1_inf_sign_reg;
            s2_exp_reg      <= s1_exp_reg;
            s2_sum_reg      <= sum;
            out_valid_reg   <= s2_valid_reg;
            out_reg         <= res;
            nan_reg         <= s2_valid_reg & res_nan;
            ovf_reg         <= s2_valid_reg & res_ovf;
        end
    end

    assign out_valid     = out_valid_reg;
    assign out           = out_reg;
    assign NaN_flag      = nan_reg;
    assign overflow_flag = ovf_reg;
endmodule

// File: doc/float_adder_pipe.md
FLOAT_ADDER_PIPE -- requirements
Module: float_adder_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent width in bits.
REQ-002 SHALL have parameter MAN_W, default 23: stored mantissa width in bits; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands A, B, op present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port op  input  1  0 = A+B, 1 = A-B.
REQ-008 SHALL have port A  input  W  operand, IEEE-754 layout {sign, exp, mantissa}.
REQ-009 SHALL have port B  input  W  operand, same layout.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port out  output  W  result.
REQ-013 SHALL have port NaN_flag  output  1  result is NaN, qualified by out_valid.
REQ-014 SHALL have port overflow_flag  output  1  finite operands produced infinity, qualified by out_valid.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/compare/align, S2 significand add/subtract, S3 normalise/round/pack/special-case select.
REQ-016 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-017 SHALL advance all stages together when adv = !out_valid || out_ready; in_ready = adv; stall freezes every stage register.
REQ-018 SHALL give latency exactly 3 cycles from input transfer to out_valid when out_ready held high; throughput one result per cycle; results in input order.
REQ-019 SHALL not compress bubbles; empty stages propagate as invalid.
REQ-020 SHALL hold out, NaN_flag, overflow_flag stable while out_valid && !out_ready.
REQ-021 SHALL implement op=1 by inverting the sign of B before S1.
REQ-022 SHALL flush subnormal inputs (exp==0) to signed zero; results below minimum normal SHALL be +0 or signed zero per sign.
REQ-023 SHALL align the smaller-exponent significand with right shift, retaining guard, round and sticky bits; shift >= MAN_W+3 leaves only sticky.
REQ-024 SHALL produce +0 for exact cancellation (x + -x).
REQ-025 SHALL output canonical quiet NaN {0, all-ones exp, 1, zeros} with NaN_flag=1 when either operand is NaN or operands are opposite-signed infinities.
REQ-026 SHALL pass an infinite operand through (correct sign), NaN_flag=0, overflow_flag=0, when the other is finite.
REQ-027 SHALL output signed infinity with overflow_flag=1 when finite operands yield biased exponent >= all-ones after normalisation/rounding.
REQ-028 SHALL never assert NaN_flag and overflow_flag together.

Reset
REQ-029 SHALL, while rst_n low, clear all stage valids, out_valid=0, out=0, NaN_flag=0, overflow_flag=0; in_ready=1 after reset.
REQ-030 SHALL discard in-flight operations on reset assertion mid-operation; no result for them appears after release.

Configuration
REQ-031 SHALL, with macro FADD_ROUND_NEAREST_EN defined, round to nearest, ties to even, using guard/round/sticky; rounding carry SHALL renormalise and may trigger REQ-027.
REQ-032 SHALL, without FADD_ROUND_NEAREST_EN, round toward zero (truncate); latency and interface unchanged either way.

Verification
REQ-033 SHALL cover: op=0, A=0x3F800000, B=0x40000000 -> out=0x40400000 three cycles later, flags 0.
REQ-034 SHALL cover: A=0x7F800000, B=0xFF800000 -> out=0x7FC00000, NaN_flag=1; A=0xFF800000, B=0x00000000 -> out=0xFF800000, flags 0.
REQ-035 SHALL cover: A=B=0x7F7FFFFF -> out=0x7F800000, overflow_flag=1; op=1, A=B=0x3F800000 -> out=0x00000000.
REQ-036 SHALL cover: A=0x3F800001, B=0x33800000 -> 0x3F800002 with FADD_ROUND_NEAREST_EN, 0x3F800001 without.
REQ-037 SHALL cover: out_ready low, in_valid high, 5 distinct inputs -> in_ready drops after 3 accepted; raising out_ready drains all 5 in order, none lost or duplicated.
REQ-038 SHALL cover: rst_n pulsed low with 2 operations in flight -> out_valid=0, no stale result emitted after release.
